// File: rtl/reg_file_operand.sv
// Register file and operand-issue stage feeding the ALU: two bypassed read
// ports, A/B operand muxing, one registered issue slot, and the ALU flag register.
module reg_file_operand #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [IMM_W-1:0]  imm,
    input  logic              imm_sext,
    input  logic              b_sel_imm,
    input  logic              a_sel_shamt,
    input  logic [4:0]        shamt,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flag_we,
    input  logic              ofa_in,
    input  logic              zfa_in,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              out_valid,
    output logic [1:0]        flags
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] src_rs;
    logic [DATA_W-1:0] src_rt;
    logic [DATA_W-1:0] ext_imm;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;
    logic              wr_live;

    // Register 0 never takes a write, so it also never bypasses.
    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Same-cycle write-back is forwarded so a dependent issue sees the new value.
    always_comb begin
        src_rs = regs[rs_addr];
        if (rs_addr == '0) begin
            src_rs = '0;
        end else if (wr_live && (wr_addr == rs_addr)) begin
            src_rs = wr_data;
        end
    end

    always_comb begin
        src_rt = regs[rt_addr];
        if (rt_addr == '0) begin
            src_rt = '0;
        end else if (wr_live && (wr_addr == rt_addr)) begin
            src_rt = wr_data;
        end
    end

    assign ext_imm = {{(DATA_W-IMM_W){imm_sext & imm[IMM_W-1]}}, imm};
    assign a_next  = a_sel_shamt ? {{(DATA_W-5){1'b0}}, shamt} : src_rs;
    assign b_next  = b_sel_imm ? ext_imm : src_rt;

    // Handshake: no ready exists; every edge with in_valid=1 is an accepted issue,
    // and out_valid is a one-cycle strobe marking op_a/op_b from that issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a      <= '0;
            op_b      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                op_a <= a_next;
                op_b <= b_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 2'b00;
        end else if (flag_we) begin
            flags <= {ofa_in, zfa_in};
        end
    end

endmodule

// File: tb/tb_reg_file_operand.sv
// Directed bench for reg_file_operand: reset, write/issue, r0, bypass,
// immediate/shamt selection, flags and back-to-back issue.
module tb_reg_file_operand;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [15:0] imm;
    logic        imm_sext;
    logic        b_sel_imm;
    logic        a_sel_shamt;
    logic [4:0]  shamt;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        flag_we;
    logic        ofa_in;
    logic        zfa_in;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic [1:0]  flags;

    int tests_run;
    int tests_failed;

    reg_file_operand #(.DATA_W(32), .ADDR_W(5), .IMM_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm),
        .imm_sext(imm_sext), .b_sel_imm(b_sel_imm), .a_sel_shamt(a_sel_shamt),
        .shamt(shamt), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .flag_we(flag_we), .ofa_in(ofa_in), .zfa_in(zfa_in),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid = 0; rs_addr = 0; rt_addr = 0; imm = 0; imm_sext = 0;
        b_sel_imm = 0; a_sel_shamt = 0; shamt = 0; wr_en = 0; wr_addr = 0;
        wr_data = 0; flag_we = 0; ofa_in = 0; zfa_in = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        idle();
        #3;
        tests_run++;
        if (op_a !== 32'h0 || op_b !== 32'h0 || out_valid !== 1'b0 || flags !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_init: op_a=%h op_b=%h v=%b flags=%b, want all 0", op_a, op_b, out_valid, flags);
        end
        tick();
        rst_n = 1;
        wr_en = 1; wr_addr = 7; wr_data = 32'hCAFE_0007;
        flag_we = 1; ofa_in = 1; zfa_in = 1;
        tick();
        idle();
        in_valid = 1; rs_addr = 7; rt_addr = 7;
        tick();
        tests_run++;
        if (op_a !== 32'hCAFE_0007 || out_valid !== 1'b1 || flags !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_preload: op_a=%h v=%b flags=%b, want cafe0007 1 11", op_a, out_valid, flags);
        end
        // Issue still pending when reset hits mid-cycle.
        #2;
        rst_n = 0;
        #1;
        tests_run++;
        if (op_a !== 32'h0 || op_b !== 32'h0 || out_valid !== 1'b0 || flags !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_async: op_a=%h op_b=%h v=%b flags=%b, want all 0", op_a, op_b, out_valid, flags);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || op_a !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_discard: op_a=%h v=%b, want 0 0", op_a, out_valid);
        end
        rst_n = 1;
        idle();
        for (int i = 1; i < 32; i++) begin
            in_valid = 1; rs_addr = i[4:0]; rt_addr = i[4:0];
            tick();
            tests_run++;
            if (op_a !== 32'h0 || op_b !== 32'h0 || out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_regs r%0d: op_a=%h op_b=%h v=%b, want 0 0 1", i, op_a, op_b, out_valid);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_write_issue;
        wr_en = 1; wr_addr = 3; wr_data = 32'h0000_00F0;
        tick();
        wr_addr = 4; wr_data = 32'h0000_000F;
        tick();
        idle();
        in_valid = 1; rs_addr = 3; rt_addr = 4;
        tick();
        tests_run++;
        if (op_a !== 32'h0000_00F0 || op_b !== 32'h0000_000F || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_issue: op_a=%h op_b=%h v=%b, want 000000f0 0000000f 1", op_a, op_b, out_valid);
        end
        idle();
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || op_a !== 32'h0000_00F0 || op_b !== 32'h0000_000F) begin
            tests_failed++;
            $display("FAIL write_issue_hold: op_a=%h op_b=%h v=%b, want 000000f0 0000000f 0", op_a, op_b, out_valid);
        end
    endtask

    task automatic test_r0;
        wr_en = 1; wr_addr = 0; wr_data = 32'hDEAD_BEEF;
        in_valid = 1; rs_addr = 0; rt_addr = 0;
        tick();
        tests_run++;
        if (op_a !== 32'h0 || op_b !== 32'h0) begin
            tests_failed++;
            $display("FAIL r0_bypass: op_a=%h op_b=%h, want 0 0", op_a, op_b);
        end
        idle();
        in_valid = 1; rs_addr = 0; rt_addr = 0;
        tick();
        tests_run++;
        if (op_a !== 32'h0 || op_b !== 32'h0) begin
            tests_failed++;
            $display("FAIL r0_stored: op_a=%h op_b=%h, want 0 0", op_a, op_b);
        end
        idle();
    endtask

    task automatic test_bypass;
        wr_en = 1; wr_addr = 5; wr_data = 32'h1234_5678;
        in_valid = 1; rs_addr = 5; rt_addr = 5;
        tick();
        tests_run++;
        if (op_a !== 32'h1234_5678 || op_b !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL bypass: op_a=%h op_b=%h, want 12345678 12345678", op_a, op_b);
        end
        idle();
        in_valid = 1; rs_addr = 5; rt_addr = 3;
        tick();
        tests_run++;
        if (op_a !== 32'h1234_5678 || op_b !== 32'h0000_00F0) begin
            tests_failed++;
            $display("FAIL bypass_stored: op_a=%h op_b=%h, want 12345678 000000f0", op_a, op_b);
        end
        idle();
    endtask

    task automatic test_imm_shamt;
        in_valid = 1; rt_addr = 3; b_sel_imm = 1; imm = 16'hFFFE; imm_sext = 1;
        tick();
        tests_run++;
        if (op_b !== 32'hFFFF_FFFE) begin
            tests_failed++;
            $display("FAIL imm_sext: op_b=%h, want fffffffe", op_b);
        end
        imm_sext = 0;
        tick();
        tests_run++;
        if (op_b !== 32'h0000_FFFE) begin
            tests_failed++;
            $display("FAIL imm_zext: op_b=%h, want 0000fffe", op_b);
        end
        imm = 16'h7FFE; imm_sext = 1;
        tick();
        tests_run++;
        if (op_b !== 32'h0000_7FFE) begin
            tests_failed++;
            $display("FAIL imm_sext_pos: op_b=%h, want 00007ffe", op_b);
        end
        b_sel_imm = 0; rs_addr = 3; a_sel_shamt = 1; shamt = 4;
        tick();
        tests_run++;
        if (op_a !== 32'h0000_0004 || op_b !== 32'h0000_00F0) begin
            tests_failed++;
            $display("FAIL shamt4: op_a=%h op_b=%h, want 00000004 000000f0", op_a, op_b);
        end
        shamt = 31;
        tick();
        tests_run++;
        if (op_a !== 32'h0000_001F) begin
            tests_failed++;
            $display("FAIL shamt31: op_a=%h, want 0000001f", op_a);
        end
        idle();
    endtask

    task automatic test_flags;
        flag_we = 1; ofa_in = 1; zfa_in = 0;
        tick();
        tests_run++;
        if (flags !== 2'b10) begin
            tests_failed++;
            $display("FAIL flags_capture: flags=%b, want 10", flags);
        end
        flag_we = 0; ofa_in = 0; zfa_in = 1;
        tick();
        tests_run++;
        if (flags !== 2'b10) begin
            tests_failed++;
            $display("FAIL flags_hold: flags=%b, want 10", flags);
        end
        flag_we = 1;
        tick();
        tests_run++;
        if (flags !== 2'b01) begin
            tests_failed++;
            $display("FAIL flags_recapture: flags=%b, want 01", flags);
        end
        idle();
    endtask

    task automatic test_back_to_back;
        logic [4:0]  addrs [3];
        logic [31:0] exp   [3];
        addrs[0] = 3; addrs[1] = 4; addrs[2] = 5;
        exp[0] = 32'h0000_00F0; exp[1] = 32'h0000_000F; exp[2] = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; rs_addr = addrs[i]; rt_addr = addrs[2-i];
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || op_a !== exp[i] || op_b !== exp[2-i]) begin
                tests_failed++;
                $display("FAIL b2b_%0d: op_a=%h op_b=%h v=%b, want %h %h 1", i, op_a, op_b, out_valid, exp[i], exp[2-i]);
            end
        end
        // Write-back, flag capture and issue together.
        wr_en = 1; wr_addr = 6; wr_data = 32'hA5A5_5A5A;
        flag_we = 1; ofa_in = 1; zfa_in = 1;
        in_valid = 1; rs_addr = 6; rt_addr = 6;
        tick();
        tests_run++;
        if (op_a !== 32'hA5A5_5A5A || op_b !== 32'hA5A5_5A5A || out_valid !== 1'b1 || flags !== 2'b11) begin
            tests_failed++;
            $display("FAIL simultaneous: op_a=%h op_b=%h v=%b flags=%b, want a5a55a5a a5a55a5a 1 11",
                     op_a, op_b, out_valid, flags);
        end
        idle();
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_end: v=%b, want 0", out_valid);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_write_issue();
        test_r0();
        test_bypass();
        test_imm_shamt();
        test_flags();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_file_operand.md
Name: reg_file_operand

Overview:
- Register file plus operand-issue stage directly upstream of the ALU in the R/I-type CPU.
- Holds 32 general registers and reads two source registers (rs, rt).
- Selects the A/B operands (register, immediate or shift amount) and presents them registered to the ALU dina/dinb inputs with a valid strobe.
- Accepts ALU write-back and captures the ALU overflow/zero flags into a status register.

Parameters:
- DATA_W, 32, register and operand width.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- IMM_W, 16, immediate field width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  issue request; operands latched this cycle.
- rs_addr  input  ADDR_W  source register for A.
- rt_addr  input  ADDR_W  source register for B.
- imm  input  IMM_W  instruction immediate.
- imm_sext  input  1  1 = sign-extend imm, 0 = zero-extend.
- b_sel_imm  input  1  1 = B from extended imm, 0 = B from rt.
- a_sel_shamt  input  1  1 = A from zero-extended shamt, 0 = A from rs.
- shamt  input  5  shift amount; ALU op 111 shifts dinb by dina.
- wr_en  input  1  write-back enable.
- wr_addr  input  ADDR_W  write-back destination.
- wr_data  input  DATA_W  write-back data (ALU douta).
- flag_we  input  1  capture flags.
- ofa_in  input  1  ALU overflow.
- zfa_in  input  1  ALU zero.
- op_a  output  DATA_W  registered operand to ALU dina.
- op_b  output  DATA_W  registered operand to ALU dinb.
- out_valid  output  1  op_a/op_b valid.
- flags  output  2  {of, zf} status register.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers, op_a, op_b and flags clear to 0.
  - out_valid clears to 0.
  - Reset mid-issue discards the pending operand.
- Register 0 is hardwired to 0: writes to it are ignored and reads of it return 0.
- Write: on the clk rising edge when wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
- Read is combinational from the array, with write-to-read bypass:
  - If wr_en=1, wr_addr!=0 and wr_addr equals rs_addr (or rt_addr), that source sees wr_data in the same cycle.
  - This covers a back-to-back write then read.
- Operand selection:
  - A = a_sel_shamt ? {zeros, shamt} : src_rs.
  - B = b_sel_imm ? ext(imm) : src_rt.
  - ext is sign or zero extension of IMM_W to DATA_W, chosen by imm_sext.
- Issue latency is 1 cycle.
  - When in_valid=1 at a rising edge, op_a <= A, op_b <= B, out_valid <= 1.
  - When in_valid=0, out_valid <= 0 and op_a/op_b hold their last values.
  - Back-to-back issues are accepted every cycle; there is no backpressure.
- Flags: on a rising edge with flag_we=1, flags <= {ofa_in, zfa_in}; otherwise flags hold.
- Simultaneous events:
  - Write-back, flag capture and issue may all occur in one cycle.
  - The issued operands reflect the bypassed new data.
- Out-of-range handling: none needed; every ADDR_W value is a valid index.

Test Plan:
- Reset: assert rst_n=0 mid-issue -> op_a=op_b=0, out_valid=0, flags=2'b00 immediately; after release, reading r1..r31 returns 0.
- Write then issue: write r3=0x0000_00F0, write r4=0x0000_000F; next cycle issue rs=3, rt=4 -> one cycle later op_a=0x0000_00F0, op_b=0x0000_000F, out_valid=1 for exactly one cycle.
- r0 protection: write r0=0xDEAD_BEEF, issue rs=0 -> op_a=0.
- Bypass: in the same cycle write r5=0x1234_5678 and issue rs=5 -> op_a=0x1234_5678.
- Immediate and shift:
  - imm=0xFFFE with imm_sext=1, b_sel_imm=1 -> op_b=0xFFFF_FFFE.
  - The same imm with imm_sext=0 -> op_b=0x0000_FFFE.
  - a_sel_shamt=1, shamt=4 -> op_a=0x0000_0004.
- Flags: flag_we=1 with ofa_in=1, zfa_in=0 -> flags=2'b10; the next cycle with flag_we=0 and changed inputs -> flags still 2'b10.
